pipe_stall_ctrl: RTL and testbench

- Receives stall and flush requests and turns them into per-stage enable, flush and bubble controls for the 5-stage MIPS pipeline.
- Request sources:
  - load-use requests from the hazard detection unit;
  - taken-branch/jump resolution from EX;
  - the data-memory ready handshake from MEM.
- Adds a multi-cycle memory-wait state machine, a wait-timeout watchdog and saturating stall/flush performance counters.

---
 rtl/pipe_stall_if.sv | 33 +++
 rtl/pipe_stall_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_if.sv
// Handshake bundle between the 5-stage pipeline and its stall/flush controller.
// The pipeline side (master) raises requests; the controller side (slave) drives stage controls.
interface pipe_stall_if #(
  parameter int CNT_W = 16
);
  logic             ld_use_req;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_bubble;
  logic             exmem_en;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ld_use_req, branch_taken, dmem_req, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
    input  busy, timeout_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  ld_use_req, branch_taken, dmem_req, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
    output busy, timeout_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use, taken branch and
// multi-cycle data-memory waits, with a wait watchdog and saturating perf counters.
module pipe_stall_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 64
) (
  input logic         clk,
  input logic         rst,
  pipe_stall_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q, flush_q;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en;
  logic hazards_live;

  // Next-state and stage controls. Outputs depend on the live requests so a
  // hazard stalls the pipeline in the very cycle it is raised.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a variable unassigned and no latch is inferred.
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    hazards_live = 1'b0;
    state_d      = state_q;
    wait_d       = wait_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      RUN: begin
        if (bus.dmem_req && !bus.dmem_ready) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_ONE;
        end else begin
          hazards_live = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          // Requests held during the freeze take effect in the release cycle.
          hazards_live = 1'b1;
          state_d      = RUN;
          wait_d       = '0;
        end else if (wait_q == WAIT_LIM) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end

      HALT: begin
        hazards_live = 1'b0;
      end

      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase

    if (!hazards_live) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (bus.branch_taken) begin
      // The load-use consumer sitting in ID is squashed, so the branch wins.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (bus.ld_use_req) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end

    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_bubble = 1'b0;
      exmem_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      if (!pc_en && stall_q != CNT_SAT) stall_q <= stall_q + 1'b1;
      if (ifid_flush && flush_q != CNT_SAT) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_en     = idex_en;
  assign bus.idex_bubble = idex_bubble;
  assign bus.exmem_en    = exmem_en;
  assign bus.busy        = (state_q != RUN);
  assign bus.timeout_err = timeout_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios plus random traffic,
// checked every cycle against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;
  localparam int CNT_W    = 5;
  localparam int WAIT_W   = 8;
  localparam int MAX_WAIT = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  typedef struct {
    int cyc;
    bit pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en;
    bit busy, terr;
    int stall, flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_stall_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(.CNT_W(CNT_W), .WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model: "halted", "cycles spent waiting" and plain integer counters.
  bit m_halt;
  int m_wait;
  int m_stall, m_flush;
  bit m_terr;

  task automatic check(string name, int c, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  function automatic exp_t model(bit r, bit ld, bit br, bit req, bit rdy);
    exp_t e;
    bit   frozen;
    e.cyc = cyc;
    if (r) begin
      m_halt = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_terr = 0;
      e.pc_en = 0; e.ifid_en = 0; e.ifid_flush = 0; e.idex_en = 0;
      e.idex_bubble = 0; e.exmem_en = 0; e.busy = 0; e.terr = 0;
      e.stall = 0; e.flush = 0;
      return e;
    end
    e.busy  = m_halt || (m_wait > 0);
    e.terr  = m_terr;
    e.stall = m_stall;
    e.flush = m_flush;
    if (m_halt)          frozen = 1;
    else if (m_wait > 0) frozen = !rdy;
    else                 frozen = req && !rdy;

    e.pc_en = !frozen; e.ifid_en = !frozen; e.idex_en = !frozen; e.exmem_en = !frozen;
    e.ifid_flush = 0; e.idex_bubble = 0;
    if (!frozen && br) begin
      e.ifid_flush = 1; e.idex_bubble = 1;
    end else if (!frozen && ld) begin
      e.pc_en = 0; e.ifid_en = 0; e.idex_bubble = 1;
    end

    if (!m_halt) begin
      if (m_wait == 0) begin
        if (req && !rdy) m_wait = 1;
      end else if (rdy) begin
        m_wait = 0;
      end else if (m_wait == MAX_WAIT) begin
        m_halt = 1; m_terr = 1;
      end else begin
        m_wait++;
      end
    end
    if (!e.pc_en && m_stall < CNT_MAX) m_stall++;
    if (e.ifid_flush && m_flush < CNT_MAX) m_flush++;
    return e;
  endfunction

  // One cycle of stimulus, applied just after the rising edge; rst is applied
  // mid-cycle too, which exercises the asynchronous reset path.
  task automatic step(bit r, bit ld, bit br, bit req, bit rdy);
    @(posedge clk);
    #1;
    rst              = r;
    bus.ld_use_req   = ld;
    bus.branch_taken = br;
    bus.dmem_req     = req;
    bus.dmem_ready   = rdy;
    cyc++;
    sb.push_back(model(r, ld, br, req, rdy));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every presented output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc_en",       e.cyc, 32'(bus.pc_en),       32'(e.pc_en));
        check("ifid_en",     e.cyc, 32'(bus.ifid_en),     32'(e.ifid_en));
        check("ifid_flush",  e.cyc, 32'(bus.ifid_flush),  32'(e.ifid_flush));
        check("idex_en",     e.cyc, 32'(bus.idex_en),     32'(e.idex_en));
        check("idex_bubble", e.cyc, 32'(bus.idex_bubble), 32'(e.idex_bubble));
        check("exmem_en",    e.cyc, 32'(bus.exmem_en),    32'(e.exmem_en));
        check("busy",        e.cyc, 32'(bus.busy),        32'(e.busy));
        check("timeout_err", e.cyc, 32'(bus.timeout_err), 32'(e.terr));
        check("stall_cnt",   e.cyc, 32'(bus.stall_cnt),   32'(e.stall));
        check("flush_cnt",   e.cyc, 32'(bus.flush_cnt),   32'(e.flush));
      end
    end
  end

  initial begin
    bus.ld_use_req   = 0;
    bus.branch_taken = 0;
    bus.dmem_req     = 0;
    bus.dmem_ready   = 0;

    // Reset, then idle.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(5);

    // Single-cycle load-use stall, then branch overriding load-use.
    step(0, 1, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    idle(2);

    // Zero-wait access with a concurrent load-use.
    step(0, 1, 0, 1, 1);
    idle(1);

    // Memory wait released on the third cycle.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    idle(2);

    // Branch held across a freeze acts only in the release cycle.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 1);
    idle(2);

    // Watchdog: never ready -> HALT, long enough to saturate stall_cnt, then reset.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, i[0], i[1], 1, 0);
    step(1, 0, 0, 0, 0);
    idle(3);

    // Saturate flush_cnt with back-to-back branches.
    for (int i = 0; i < 40; i++) step(0, 0, 1, 0, 0);
    idle(2);

    // Random traffic with occasional resets.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 45);
    end
    idle(2);

    repeat (3) @(posedge clk);
    check("sb_drained", cyc, 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
